jt03_wr_seq: RTL
================

# jt03_wr_seq

Register-write sequencer for the jt03 (YM2203) CPU bus port. Requesters push {register, value} pairs into a small FIFO. The block replays each pair as the chip's two-phase write: an address write (A0=0) followed by a data write (A0=1). It enforces the chip's post-write wait times and optionally polls the status busy flag. It sits between the system/softcore register master and the jt03 `din/addr/cs_n/wr_n/dout` pins, and replaces direct CPU bit-banging.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, minimum 2.
- `WR_CYC`, 2: cen cycles that `ym_cs_n`/`ym_wr_n` are held low per bus write.
- `ADDR_WAIT`, 8: cen cycles idle after the address write, before the data write.
- `DATA_WAIT`, 32: cen cycles idle after the data write.
- `POLL_BUSY`, 1: 1 = after `DATA_WAIT`, wait for `ym_din[7]==0`.
- `BUSY_MAX`, 255: cen-cycle timeout for the busy poll.

Ports:
- `clk` in 1: system clock, the same clock as jt03 `clk`.
- `rst` in 1: asynchronous, active-high reset.
- `cen` in 1: clock enable shared with jt03. All counters and FSM moves happen only when `cen`=1.
- `wr_valid` in 1: request valid.
- `wr_ready` out 1: request accepted when `wr_valid & wr_ready` at a `clk` edge (independent of `cen`).
- `wr_reg` in 8: target register number.
- `wr_val` in 8: value to write.
- `ym_din` in 8: jt03 `dout` (status); bit 7 is busy.
- `ym_dout` out 8: to jt03 `din`.
- `ym_addr` out 1: to jt03 `addr` (A0).
- `ym_cs_n` out 1: to jt03 `cs_n`.
- `ym_wr_n` out 1: to jt03 `wr_n`.
- `idle` out 1: FIFO empty and FSM in IDLE.
- `timeout` out 1: sticky; set when a busy poll exceeds `BUSY_MAX`; cleared only by `rst`.

## Operation
- FIFO: 16-bit entries, pointers of log2(`DEPTH`)+1 bits, count 0..`DEPTH`.
  - `wr_ready = (count != DEPTH)`; it is combinational from the registered count.
  - Push and pop in the same edge leave count unchanged.
  - A push when full cannot occur, because `wr_ready` is low.
- FSM states:
  - IDLE:
    - cen & !empty → pop entry into `cur_reg/cur_val`, go A_WR.
  - A_WR:
    - Drives `ym_addr`=0, `ym_dout`=`cur_reg`, `ym_cs_n`=0, `ym_wr_n`=0.
    - After `WR_CYC` cen cycles → A_HOLD.
  - A_HOLD:
    - Strobes high, `ym_addr`=0, `ym_dout` held.
    - After `ADDR_WAIT` cen cycles → D_WR.
  - D_WR:
    - Drives `ym_addr`=1, `ym_dout`=`cur_val`, strobes low.
    - After `WR_CYC` cen cycles → D_HOLD.
  - D_HOLD:
    - Strobes high.
    - After `DATA_WAIT` cen cycles → BUSY if `POLL_BUSY`, else to done.
  - BUSY:
    - Strobes high, `ym_addr`=0.
    - cen & `ym_din[7]`==0 → done.
    - Otherwise count; at `BUSY_MAX` cen cycles, set `timeout` and go to done.
  - done: if !empty, pop and go A_WR directly (back-to-back, no IDLE cycle); else go IDLE.
- One down-counter is shared. It is loaded with (N−1) on state entry, a state exits on cen when the counter is 0, and a parameter of 0 is treated as 1.
- All `ym_*` outputs are registered; no glitches on `ym_cs_n`/`ym_wr_n`.

## Timing
- Reset values: `ym_cs_n`=1, `ym_wr_n`=1, `ym_addr`=0, `ym_dout`=0x00, `idle`=1, `timeout`=0, FIFO empty, `wr_ready`=1 after release.
- Latency with `cen`=1, request accepted at edge E0:
  - The FSM pops at E1.
  - `ym_cs_n` is low from E1 to E1+`WR_CYC`.
  - The data strobe starts at E1+`WR_CYC`+`ADDR_WAIT`.
- Per-write occupancy with busy already clear: 2·`WR_CYC`+`ADDR_WAIT`+`DATA_WAIT`+(`POLL_BUSY`?1:0) cen cycles.
- `cen`=0 freezes the FSM, counter and outputs. The FIFO still accepts pushes.
- Reset asserted mid-write: outputs return to reset values immediately (asynchronously), the FIFO is flushed and the partial write is dropped.
- `idle` is registered. It rises the cycle after the final state exit, when the FIFO is empty.

## Test plan
- Single push (0x28, 0xF1) with `cen`=1 and `ym_din`=0 → address strobe of 2 cycles with dout=0x28/A0=0, then 8 idle cycles, then data strobe of 2 cycles with dout=0xF1/A0=1, then 32 cycles + 1 poll; `idle` returns after 45 cycles.
- 6 consecutive pushes with `wr_valid` held → 4 accepted while the first is in flight (5 total before `wr_ready` falls); all 6 eventually emitted in order with no IDLE gap.
- `ym_din[7]`=1 for 10 cycles after D_HOLD → FSM remains in BUSY exactly 10 cycles; next write starts the cycle after busy clears.
- `ym_din[7]` stuck at 1 → `timeout` sets after 255 cycles in BUSY; the sequencer proceeds to the next entry; `timeout` stays 1 until `rst`.
- `cen` toggling 1-of-3 → every strobe and wait spans 3× the clk cycles; push accepted during `cen`=0.
- `rst` pulsed during D_WR with 2 entries queued → strobes high within the reset cycle, `idle`=1, `wr_ready`=1, and no further bus activity.

Source files
------------

// File: rtl/jt03_wr_seq.sv
// rtl/jt03_wr_seq.sv - YM2203 register-write sequencer with request FIFO
//
// Queues {register, value} requests and replays each one on the jt03 CPU
// port as an address write (A0=0) then a data write (A0=1). It observes the
// chip's post-write wait times and can poll the status busy flag.
//
// Ports:
//   clk, rst           system clock, asynchronous active-high reset
//   cen                clock enable shared with jt03; the FSM moves only when it is high
//   wr_valid/wr_ready  request handshake; a push is accepted on any clk edge
//   wr_reg, wr_val     register number and value of the request
//   ym_din             jt03 dout (status), bit 7 = busy
//   ym_dout, ym_addr   jt03 din and A0 (registered)
//   ym_cs_n, ym_wr_n   jt03 strobes (registered, glitch free)
//   idle               FIFO empty and sequencer idle (registered)
//   timeout            sticky busy-poll timeout flag
module jt03_wr_seq #(
  parameter int DEPTH     = 4,
  parameter int WR_CYC    = 2,
  parameter int ADDR_WAIT = 8,
  parameter int DATA_WAIT = 32,
  parameter int POLL_BUSY = 1,
  parameter int BUSY_MAX  = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_reg,
  input  logic [7:0] wr_val,
  input  logic [7:0] ym_din,
  output logic [7:0] ym_dout,
  output logic       ym_addr,
  output logic       ym_cs_n,
  output logic       ym_wr_n,
  output logic       idle,
  output logic       timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = 16;
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, A_WR, A_HOLD, D_WR, D_HOLD, BUSY} state_t;

  // Counter preload for an N-cycle state; N=0 behaves like N=1.
  function automatic logic [CW-1:0] load_val(input int n);
    if (n <= 1) return '0;
    return CW'(n - 1);
  endfunction

  logic [15:0]   mem [DEPTH];
  logic [AW:0]   wptr, rptr, count, count_n;
  logic [15:0]   head;
  logic          push, pop, empty;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    cur_reg, cur_val;
  logic          done, to_set;
  logic          strobe_n, addr_n;
  logic [7:0]    dout_n;
  logic          unused_din;

  assign unused_din = ^ym_din[6:0];

  assign empty    = (count == '0);
  assign wr_ready = (count != FULL);
  assign push     = wr_valid & wr_ready;
  assign head     = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= {wr_reg, wr_val};
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pop     = 1'b0;
    done    = 1'b0;
    to_set  = 1'b0;
    if (cen) begin
      case (state)
        IDLE: begin
          if (!empty) begin
            pop     = 1'b1;
            state_n = A_WR;
            cnt_n   = load_val(WR_CYC);
          end
        end
        A_WR: begin
          if (cnt == '0) begin
            state_n = A_HOLD;
            cnt_n   = load_val(ADDR_WAIT);
          end else cnt_n = cnt - 1'b1;
        end
        A_HOLD: begin
          if (cnt == '0) begin
            state_n = D_WR;
            cnt_n   = load_val(WR_CYC);
          end else cnt_n = cnt - 1'b1;
        end
        D_WR: begin
          if (cnt == '0) begin
            state_n = D_HOLD;
            cnt_n   = load_val(DATA_WAIT);
          end else cnt_n = cnt - 1'b1;
        end
        D_HOLD: begin
          if (cnt == '0) begin
            if (POLL_BUSY != 0) begin
              state_n = BUSY;
              cnt_n   = load_val(BUSY_MAX);
            end else done = 1'b1;
          end else cnt_n = cnt - 1'b1;
        end
        BUSY: begin
          if (!ym_din[7]) done = 1'b1;
          else if (cnt == '0) begin
            done   = 1'b1;
            to_set = 1'b1;
          end else cnt_n = cnt - 1'b1;
        end
        default: state_n = IDLE;
      endcase
      // Finishing a write chains straight into the next queued entry.
      if (done) begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = A_WR;
          cnt_n   = load_val(WR_CYC);
        end else state_n = IDLE;
      end
    end
  end

  assign count_n = count + (push ? PTR_ONE : '0) - (pop ? PTR_ONE : '0);

  // Bus outputs are derived from the next state so they change on the same
  // edge the state does, straight out of flops.
  always_comb begin
    strobe_n = (state_n == A_WR) || (state_n == D_WR);
    addr_n   = (state_n == D_WR) || (state_n == D_HOLD);
    dout_n   = ym_dout;
    if (state_n == A_WR)      dout_n = pop ? head[15:8] : cur_reg;
    else if (state_n == D_WR) dout_n = cur_val;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      cur_reg <= 8'h00;
      cur_val <= 8'h00;
      ym_dout <= 8'h00;
      ym_addr <= 1'b0;
      ym_cs_n <= 1'b1;
      ym_wr_n <= 1'b1;
      idle    <= 1'b1;
      timeout <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      count <= count_n;
      if (push) wptr <= wptr + PTR_ONE;
      if (pop) begin
        rptr    <= rptr + PTR_ONE;
        cur_reg <= head[15:8];
        cur_val <= head[7:0];
      end
      if (to_set) timeout <= 1'b1;
      ym_cs_n <= ~strobe_n;
      ym_wr_n <= ~strobe_n;
      ym_addr <= addr_n;
      ym_dout <= dout_n;
      idle    <= (state_n == IDLE) && (count_n == '0);
    end
  end

endmodule
